mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the word-index width of the shared instruction/data memory (256 words).
REQ-002 SHALL have parameter STARVE_MAX, default 2, meaning the maximum number of consecutive data grants while a fetch is pending.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, the asynchronous active-high reset.
REQ-005 SHALL have ports if_req_valid, input, 1; if_req_addr, input, 32; if_req_ready, output, 1 (fetch request: byte address, read only).
REQ-006 SHALL have ports if_rsp_valid, output, 1; if_rsp_data, output, 32; if_rsp_err, output, 1 (fetch response).
REQ-007 SHALL have ports d_req_valid, input, 1; d_req_we, input, 1; d_req_addr, input, 32; d_req_wdata, input, 32; d_req_ready, output, 1 (load/store request).
REQ-008 SHALL have ports d_rsp_valid, output, 1; d_rsp_data, output, 32; d_rsp_err, output, 1 (load/store response; stores also get one response).
REQ-009 SHALL have ports mem_addr, output, 32; mem_wdata, output, 32; mem_we, output, 1; mem_rdata, input, 32, which drive the memory's Address, writeData and writeEnable ports and take its readData.

Function
REQ-010 SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-011 SHALL accept a request only in IDLE or RESP; a request is accepted on a cycle where its req_valid and req_ready are both 1.
REQ-012 SHALL assert at most one of if_req_ready and d_req_ready per cycle; ready is combinational from state, the valids and the starvation counter.
REQ-013 SHALL grant data over fetch, except that fetch SHALL win when starve_cnt equals STARVE_MAX and if_req_valid is 1.
REQ-014 SHALL increment starve_cnt (saturating at STARVE_MAX) on each data grant made while if_req_valid is 1, and clear it on any fetch grant.
REQ-015 SHALL latch the granted requester's id, we, address and wdata at acceptance and enter ACCESS.
REQ-016 SHALL drive mem_addr = zero-extended latched addr[ADDR_W+1:2] in ACCESS, and mem_we = latched we AND NOT err only in ACCESS.
REQ-017 SHALL drive mem_we = 0 in IDLE and RESP, and SHALL hold mem_addr at the last value.
REQ-018 SHALL flag err when addr[1:0] != 0 or addr[31:ADDR_W+2] != 0; an erroring access SHALL NOT write memory.
REQ-019 SHALL move from ACCESS to RESP unconditionally.
REQ-020 SHALL pulse the owner's rsp_valid for exactly one cycle in RESP, with rsp_data = mem_rdata for reads, 0 for writes and 0 when err=1, and rsp_err = latched err.
REQ-021 SHALL go from RESP to ACCESS if a new request is accepted that cycle, else to IDLE; response and accept MAY coincide.
REQ-022 SHALL give fixed latency: accept in cycle N, memory access in N+1, rsp_valid in N+2; peak throughput one transaction per 2 cycles.
REQ-023 SHALL ignore a req_valid that drops before acceptance; requesters hold their request fields stable until accepted.
REQ-024 SHALL hold both rsp_valid at 0 outside RESP, and hold rsp_data at the last value.

Reset
REQ-025 SHALL, on reset assertion, immediately set state=IDLE, starve_cnt=0, mem_we=0, mem_addr=0, mem_wdata=0, all rsp_valid=0, rsp_data=0, rsp_err=0 and latched fields=0.
REQ-026 SHALL abandon an in-flight transaction on reset mid-ACCESS or mid-RESP with no response, and assert mem_we=0 asynchronously.
REQ-027 SHALL allow ready to be asserted in the first cycle after reset deasserts.

Structure
REQ-028 SHALL place the state encoding (IDLE=0, ACCESS=1, RESP=2) and the requester ids (REQ_IF=0, REQ_D=1) in shared package riscv_mem_pkg.
REQ-029 SHALL be a single module with no sub-modules; the memory is instantiated beside it at the top level.

Verification
REQ-030 Fetch-only read: the bench SHALL preload word 5=0xDEADBEEF and send if_req addr 0x14 at cycle 0; it SHALL require if_req_ready=1 at cycle 0, mem_addr=5 at cycle 1, and if_rsp_valid=1 with data 0xDEADBEEF at cycle 2.
REQ-031 Store then load: the bench SHALL send d_req we=1 addr 0x08 wdata 0x12345678, then a load of 0x08 back-to-back; it SHALL require mem_we=1 for exactly one cycle, a store response with data 0, and the load returning 0x12345678 two cycles after its accept.
REQ-032 Simultaneous requests: the bench SHALL hold if_req_valid and d_req_valid both 1 continuously; it SHALL require the grant order D, D, IF, D, D, IF with never both ready in one cycle.
REQ-033 Error access: the bench SHALL send d_req we=1 addr 0x0000_0402 and addr 0x0000_0400; it SHALL require mem_we=0 throughout, d_rsp_err=1 and data 0 for both, and memory contents unchanged.
REQ-034 Reset mid-ACCESS: the bench SHALL assert reset during ACCESS of a store; it SHALL require mem_we=0 immediately, no rsp_valid, and state IDLE with ready available one cycle after release.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, requester ids
// and the address legality check used at request acceptance.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    // Misaligned, or any bit set above the word index of a 2**aw-word memory.
    function automatic logic addr_err(input logic [31:0] a, input int unsigned aw);
        return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port memory; fixed latency accept N, access N+1, response N+2.
// Backpressure: one ready at a time, only in IDLE/RESP; data wins unless fetch has waited STARVE_MAX data grants.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,

    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    req_id_t          lat_id;
    logic             lat_we;
    logic             lat_err;

    logic             can_accept;
    logic             fetch_prio;
    logic             d_acc;
    logic             if_acc;
    logic [31:0]      sel_addr;
    logic             sel_we;
    logic [31:0]      sel_wdata;
    logic             sel_err;
    logic [31:0]      rsp_value;

    always_comb begin
        can_accept   = (state == IDLE) || (state == RESP);
        fetch_prio   = if_req_valid && (starve_cnt == STARVE_LIM);
        d_req_ready  = can_accept && d_req_valid && !fetch_prio;
        if_req_ready = can_accept && if_req_valid && !d_req_ready;
        d_acc        = d_req_valid && d_req_ready;
        if_acc       = if_req_valid && if_req_ready;
        sel_addr     = d_acc ? d_req_addr : if_req_addr;
        sel_we       = d_acc && d_req_we;
        sel_wdata    = d_acc ? d_req_wdata : 32'd0;
        sel_err      = addr_err(sel_addr, ADDR_W);
        // Errored accesses and stores both return zero data.
        rsp_value    = (lat_err || lat_we) ? 32'd0 : mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            lat_id       <= REQ_IF;
            lat_we       <= 1'b0;
            lat_err      <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_we       <= 1'b0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= 32'd0;
            if_rsp_err   <= 1'b0;
            d_rsp_valid  <= 1'b0;
            d_rsp_data   <= 32'd0;
            d_rsp_err    <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            mem_we       <= 1'b0;

            case (state)
                IDLE, RESP: begin
                    if (d_acc || if_acc) begin
                        lat_id    <= d_acc ? REQ_D : REQ_IF;
                        lat_we    <= sel_we;
                        lat_err   <= sel_err;
                        mem_addr  <= {{(32-ADDR_W){1'b0}}, sel_addr[ADDR_W+1:2]};
                        mem_wdata <= sel_wdata;
                        mem_we    <= sel_we && !sel_err;
                        state     <= ACCESS;
                    end else begin
                        state     <= IDLE;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (lat_id == REQ_D) begin
                        d_rsp_valid  <= 1'b1;
                        d_rsp_data   <= rsp_value;
                        d_rsp_err    <= lat_err;
                    end else begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_data  <= rsp_value;
                        if_rsp_err   <= lat_err;
                    end
                end
                default: state <= IDLE;
            endcase

            // Count data grants that overtook a waiting fetch.
            if (if_acc) begin
                starve_cnt <= '0;
            end else if (d_acc && if_req_valid && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a combinational-read, clocked-write memory beside it.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = 32'd0;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        d_req_valid = 1'b0;
    logic        d_req_we = 1'b0;
    logic [31:0] d_req_addr = 32'd0;
    logic [31:0] d_req_wdata = 32'd0;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    mem_arbiter #(.ADDR_W(8), .STARVE_MAX(2)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   we_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: checks ready exclusivity every cycle and pops the scoreboard on each response.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (mem_we) we_cycles++;
            total++;
            if (if_req_ready && d_req_ready) begin
                bad++;
                $display("FAIL both_ready: got if=1 d=1 want at most one (cycle %0d)", cyc);
            end
            if (if_rsp_valid || d_rsp_valid) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rsp: got if_v=%0b d_v=%0b want none (cycle %0d)",
                             if_rsp_valid, d_rsp_valid, cyc);
                end else begin
                    e = sbq.pop_front();
                    if ((if_rsp_valid && d_rsp_valid) ||
                        (d_rsp_valid != e.port) || (cyc != e.cyc) ||
                        ((e.port ? d_rsp_data : if_rsp_data) !== e.data) ||
                        ((e.port ? d_rsp_err : if_rsp_err) !== e.err)) begin
                        bad++;
                        $display("FAIL rsp: got if_v=%0b d_v=%0b data=%h err=%0b cyc=%0d want port=%0d data=%h err=%0b cyc=%0d",
                                 if_rsp_valid, d_rsp_valid, e.port ? d_rsp_data : if_rsp_data,
                                 e.port ? d_rsp_err : if_rsp_err, cyc, e.port, e.data, e.err, e.cyc);
                    end
                end
            end
        end
    end

    // Presents one request from posedge+1, holds it until accepted, returns in the ACCESS cycle.
    task automatic issue(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_d, input bit exp_e, input bit expect_rsp,
                         output int start_c, output int acc_c);
        bit   got = 0;
        exp_t e;
        if (port) begin
            d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata;
        end else begin
            if_req_valid = 1'b1; if_req_addr = addr;
        end
        start_c = cyc;
        acc_c   = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (port ? d_req_ready : if_req_ready) begin
                got   = 1;
                acc_c = cyc;
                if (expect_rsp) begin
                    e.port = port; e.data = exp_d; e.err = exp_e; e.cyc = cyc + 2;
                    sbq.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        if (port) d_req_valid = 1'b0; else if_req_valid = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no ready want ready within 20 cycles (addr %h)", addr);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int sc, ac, w0;
        bit order[$];
        bit [5:0] exp_order;
        exp_t e;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'hA5A5A5A5;
        mem[3] = 32'h0BADF00D;
        mem[5] = 32'hDEADBEEF;

        #1;
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_rsp_valid", {if_rsp_valid, d_rsp_valid}, 0);
        chk("reset_rsp_data", d_rsp_data | if_rsp_data, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Fetch-only read of word 5.
        issue(0, 0, 32'h14, 0, 32'hDEADBEEF, 0, 1, sc, ac);
        chk("fetch_ready_cycle0", ac, sc);
        @(negedge clk);
        chk("fetch_mem_addr", mem_addr, 5);
        chk("fetch_mem_we", mem_we, 0);
        drain();

        // Store then back-to-back load of the same word.
        w0 = we_cycles;
        issue(1, 1, 32'h08, 32'h12345678, 0, 0, 1, sc, ac);
        issue(1, 0, 32'h08, 0, 32'h12345678, 0, 1, sc, ac);
        chk("load_accept_in_resp", ac, sc + 1);
        drain();
        chk("store_we_cycles", we_cycles - w0, 1);
        chk("store_mem_word2", mem[2], 32'h12345678);

        // Both requesters held valid: data, data, fetch, repeated.
        if_req_valid = 1'b1; if_req_addr = 32'h14;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h08;
        for (int i = 0; i < 30 && order.size() < 6; i++) begin
            @(negedge clk);
            if (d_req_ready || if_req_ready) begin
                order.push_back(d_req_ready);
                e.port = d_req_ready;
                e.data = d_req_ready ? 32'h12345678 : 32'hDEADBEEF;
                e.err  = 0;
                e.cyc  = cyc + 2;
                sbq.push_back(e);
            end
            @(posedge clk); #1;
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        exp_order = 6'b011011;
        chk("grant_count", order.size(), 6);
        for (int i = 0; i < order.size() && i < 6; i++)
            chk($sformatf("grant_%0d_is_d", i), order[i], exp_order[i]);
        drain();

        // Out-of-range / misaligned stores must not write.
        w0 = we_cycles;
        issue(1, 1, 32'h402, 32'hFFFFFFFF, 0, 1, 1, sc, ac);
        issue(1, 1, 32'h400, 32'hFFFFFFFF, 0, 1, 1, sc, ac);
        drain();
        chk("err_we_cycles", we_cycles - w0, 0);
        chk("err_mem_word0", mem[0], 32'hA5A5A5A5);

        // Reset during a store's ACCESS cycle.
        issue(1, 1, 32'h0C, 32'hCAFEF00D, 0, 0, 0, sc, ac);
        chk("rst_access_we", mem_we, 1);
        reset = 1'b1;
        #1;
        chk("rst_async_we", mem_we, 0);
        chk("rst_no_rsp", {if_rsp_valid, d_rsp_valid}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        issue(1, 0, 32'h0C, 0, 32'h0BADF00D, 0, 1, sc, ac);
        chk("rst_ready_first_cycle", ac, sc);
        drain();
        chk("rst_mem_word3", mem[3], 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
